// File: rtl/dual_issue_scoreboard_pkg.sv
// dual_issue_scoreboard_pkg
//   Shared definitions for the dual-issue hazard scoreboard and the decode
//   wrapper around it: FSM state encoding, pipe identifiers, flush-history
//   entry layout, parameter defaults and a saturating-decrement helper.
package dual_issue_scoreboard_pkg;

  localparam int NUM_REGS_DEF    = 128;
  localparam int ADDR_W_DEF      = 7;
  localparam int LAT_W_DEF       = 4;
  localparam int FLUSH_DEPTH_DEF = 2;

  // Busy lookups: ra, rb, rc, dst for s1 then the same four for s2.
  localparam int NUM_RD_PORTS = 8;

  typedef enum logic {
    ST_PAIR   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;

  // One recorded reservation: which register it loaded and the count that
  // register should still hold if nothing else has touched it since.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] dst;
    logic [LAT_W_DEF-1:0]  exp_cnt;
  } hist_entry_t;

  function automatic logic [LAT_W_DEF-1:0] sat_dec(input logic [LAT_W_DEF-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

endpackage

// File: rtl/dual_issue_scoreboard_regfile.sv
// scoreboard_regfile
//   Per-register countdown array. Every nonzero count decrements each cycle;
//   conditional-clear ports zero a count only if it still equals the value
//   the requester expects; load ports overwrite (port 1 beats port 0).
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     ld_en_i/addr_i/val_i  two load ports (slot 1, slot 2)
//     clr_en_i/addr_i/exp_i NUM_CLR conditional-clear ports
//     rd_addr_i / busy_o    NUM_RD_PORTS busy lookups
module scoreboard_regfile
  import dual_issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int NUM_CLR  = 2 * FLUSH_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en_i    [2],
  input  logic [ADDR_W-1:0] ld_addr_i  [2],
  input  logic [LAT_W-1:0]  ld_val_i   [2],
  input  logic              clr_en_i   [NUM_CLR],
  input  logic [ADDR_W-1:0] clr_addr_i [NUM_CLR],
  input  logic [LAT_W-1:0]  clr_exp_i  [NUM_CLR],
  input  logic [ADDR_W-1:0] rd_addr_i  [NUM_RD_PORTS],
  output logic              busy_o     [NUM_RD_PORTS]
);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];

  // Clear decisions look only at pre-update counts, so an entry whose
  // register was since re-reserved by someone else is left alone.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
    end
    for (int c = 0; c < NUM_CLR; c++) begin
      if (clr_en_i[c] && (cnt_q[clr_addr_i[c]] == clr_exp_i[c])) begin
        cnt_d[clr_addr_i[c]] = '0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (ld_en_i[p]) begin
        cnt_d[ld_addr_i[p]] = ld_val_i[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      busy_o[i] = (cnt_q[rd_addr_i[i]] != '0);
    end
  end

endmodule

// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard
//   Dual-issue hazard check between decode and register fetch. Decides each
//   cycle whether s1, s2, both or neither of the presented pair issue, keeps
//   a per-register countdown of outstanding results, and on a taken-branch
//   flush retracts reservations made in the last FLUSH_DEPTH issue cycles.
//   Ports:
//     clk, rst_n             clock, async active-low reset
//     pair_valid/pair_ready  pair handshake with decode
//     s1_*/s2_*              per-slot sources, destination, latency, pipe
//     issue1, issue2, stall  zero-cycle issue decision
//     flush                  taken-branch flush
module dual_issue_scoreboard
  import dual_issue_scoreboard_pkg::*;
#(
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LAT_W       = LAT_W_DEF,
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pair_valid,
  output logic              pair_ready,
  input  logic [ADDR_W-1:0] s1_ra_addr,
  input  logic [ADDR_W-1:0] s1_rb_addr,
  input  logic [ADDR_W-1:0] s1_rc_addr,
  input  logic              s1_ra_use,
  input  logic              s1_rb_use,
  input  logic              s1_rc_use,
  input  logic [ADDR_W-1:0] s1_reg_dst,
  input  logic              s1_reg_wr,
  input  logic [LAT_W-1:0]  s1_latency,
  input  logic              s1_pipe,
  input  logic [ADDR_W-1:0] s2_ra_addr,
  input  logic [ADDR_W-1:0] s2_rb_addr,
  input  logic [ADDR_W-1:0] s2_rc_addr,
  input  logic              s2_ra_use,
  input  logic              s2_rb_use,
  input  logic              s2_rc_use,
  input  logic [ADDR_W-1:0] s2_reg_dst,
  input  logic              s2_reg_wr,
  input  logic [LAT_W-1:0]  s2_latency,
  input  logic              s2_pipe,
  output logic              issue1,
  output logic              issue2,
  output logic              stall,
  input  logic              flush
);

  localparam int NUM_CLR = 2 * FLUSH_DEPTH;

  state_e      state_q, state_d;
  hist_entry_t hist1_q [FLUSH_DEPTH];
  hist_entry_t hist1_d [FLUSH_DEPTH];
  hist_entry_t hist2_q [FLUSH_DEPTH];
  hist_entry_t hist2_d [FLUSH_DEPTH];

  logic [ADDR_W-1:0] rd_addr  [NUM_RD_PORTS];
  logic              busy     [NUM_RD_PORTS];
  logic              ld_en    [2];
  logic [ADDR_W-1:0] ld_addr  [2];
  logic [LAT_W-1:0]  ld_val   [2];
  logic              clr_en   [NUM_CLR];
  logic [ADDR_W-1:0] clr_addr [NUM_CLR];
  logic [LAT_W-1:0]  clr_exp  [NUM_CLR];

  logic hz1, hz2, cross_hz;
  logic go1, go2, stall_c, ready_c;

  scoreboard_regfile #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .LAT_W    (LAT_W),
    .NUM_CLR  (NUM_CLR)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_en_i    (ld_en),
    .ld_addr_i  (ld_addr),
    .ld_val_i   (ld_val),
    .clr_en_i   (clr_en),
    .clr_addr_i (clr_addr),
    .clr_exp_i  (clr_exp),
    .rd_addr_i  (rd_addr),
    .busy_o     (busy)
  );

  // Busy lookups and per-slot hazards; cross-slot checks apply only while s1
  // is pending or issuing alongside s2 (state PAIR).
  always_comb begin
    rd_addr[0] = s1_ra_addr;
    rd_addr[1] = s1_rb_addr;
    rd_addr[2] = s1_rc_addr;
    rd_addr[3] = s1_reg_dst;
    rd_addr[4] = s2_ra_addr;
    rd_addr[5] = s2_rb_addr;
    rd_addr[6] = s2_rc_addr;
    rd_addr[7] = s2_reg_dst;
    hz1 = (s1_ra_use & busy[0]) | (s1_rb_use & busy[1]) |
          (s1_rc_use & busy[2]) | (s1_reg_wr & busy[3]);
    hz2 = (s2_ra_use & busy[4]) | (s2_rb_use & busy[5]) |
          (s2_rc_use & busy[6]) | (s2_reg_wr & busy[7]);
    cross_hz = (s1_reg_wr & ((s2_ra_use & (s2_ra_addr == s1_reg_dst)) |
                             (s2_rb_use & (s2_rb_addr == s1_reg_dst)) |
                             (s2_rc_use & (s2_rc_addr == s1_reg_dst)) |
                             (s2_reg_wr & (s2_reg_dst == s1_reg_dst)))) |
               (s1_pipe == s2_pipe);
  end

  // Issue decision. A flush kills the pair outright: nothing issues, no
  // stall is reported, and the FSM returns to PAIR.
  always_comb begin
    go1     = 1'b0;
    go2     = 1'b0;
    stall_c = 1'b0;
    ready_c = 1'b0;
    state_d = state_q;
    if (pair_valid && !flush) begin
      if (state_q == ST_PAIR) begin
        if (hz1) begin
          stall_c = 1'b1;
        end else if (hz2 || cross_hz) begin
          go1     = 1'b1;
          state_d = ST_SECOND;
        end else begin
          go1     = 1'b1;
          go2     = 1'b1;
          ready_c = 1'b1;
        end
      end else if (!hz2) begin
        go2     = 1'b1;
        ready_c = 1'b1;
        state_d = ST_PAIR;
      end else begin
        stall_c = 1'b1;
      end
    end
    if (flush) begin
      state_d = ST_PAIR;
    end
  end

  assign issue1     = rst_n & go1;
  assign issue2     = rst_n & go2;
  assign stall      = rst_n & stall_c;
  assign pair_ready = rst_n & ready_c;

  // The issue cycle itself counts as the first cycle of latency, so the
  // stored count is L-1: a latency-L result frees its register for a
  // consumer issuing exactly L cycles after the producer.
  always_comb begin
    ld_en[0]   = go1 & s1_reg_wr & (s1_latency != '0);
    ld_addr[0] = s1_reg_dst;
    ld_val[0]  = s1_latency - 1'b1;
    ld_en[1]   = go2 & s2_reg_wr & (s2_latency != '0);
    ld_addr[1] = s2_reg_dst;
    ld_val[1]  = s2_latency - 1'b1;
  end

  // History ages in lockstep with the counts so exp_cnt tracks what the
  // register should hold if it has not been re-reserved since.
  always_comb begin
    for (int k = 0; k < FLUSH_DEPTH; k++) begin
      clr_en[k]               = flush & hist1_q[k].valid;
      clr_addr[k]             = hist1_q[k].dst;
      clr_exp[k]              = hist1_q[k].exp_cnt;
      clr_en[FLUSH_DEPTH+k]   = flush & hist2_q[k].valid;
      clr_addr[FLUSH_DEPTH+k] = hist2_q[k].dst;
      clr_exp[FLUSH_DEPTH+k]  = hist2_q[k].exp_cnt;
    end
    hist1_d[0] = '{valid: ld_en[0], dst: s1_reg_dst, exp_cnt: ld_val[0]};
    hist2_d[0] = '{valid: ld_en[1], dst: s2_reg_dst, exp_cnt: ld_val[1]};
    for (int i = 1; i < FLUSH_DEPTH; i++) begin
      hist1_d[i]         = hist1_q[i-1];
      hist1_d[i].exp_cnt = sat_dec(hist1_q[i-1].exp_cnt);
      hist2_d[i]         = hist2_q[i-1];
      hist2_d[i].exp_cnt = sat_dec(hist2_q[i-1].exp_cnt);
    end
    if (flush) begin
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
        hist1_d[i] = '0;
        hist2_d[i] = '0;
      end
    end
  end

  // FSM state and flush history share one register process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PAIR;
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
        hist1_q[i] <= '0;
        hist2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
        hist1_q[i] <= hist1_d[i];
        hist2_q[i] <= hist2_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb_dual_issue_scoreboard
//   Directed bench for dual_issue_scoreboard. Each step drives a pair just
//   after a rising edge and checks {issue1, issue2, stall, pair_ready} on
//   the following falling edge against hand-derived values.
module tb_dual_issue_scoreboard;
  import dual_issue_scoreboard_pkg::*;

  logic       clk;
  logic       rstN;
  logic       pairValid;
  logic       pairReady;
  logic [6:0] s1RaAddr, s1RbAddr, s1RcAddr, s1RegDst;
  logic       s1RaUse, s1RbUse, s1RcUse, s1RegWr, s1Pipe;
  logic [3:0] s1Latency;
  logic [6:0] s2RaAddr, s2RbAddr, s2RcAddr, s2RegDst;
  logic       s2RaUse, s2RbUse, s2RcUse, s2RegWr, s2Pipe;
  logic [3:0] s2Latency;
  logic       issue1, issue2, stall, flush;

  int testsRun    = 0;
  int testsFailed = 0;

  dual_issue_scoreboard dut (
    .clk        (clk),
    .rst_n      (rstN),
    .pair_valid (pairValid),
    .pair_ready (pairReady),
    .s1_ra_addr (s1RaAddr),
    .s1_rb_addr (s1RbAddr),
    .s1_rc_addr (s1RcAddr),
    .s1_ra_use  (s1RaUse),
    .s1_rb_use  (s1RbUse),
    .s1_rc_use  (s1RcUse),
    .s1_reg_dst (s1RegDst),
    .s1_reg_wr  (s1RegWr),
    .s1_latency (s1Latency),
    .s1_pipe    (s1Pipe),
    .s2_ra_addr (s2RaAddr),
    .s2_rb_addr (s2RbAddr),
    .s2_rc_addr (s2RcAddr),
    .s2_ra_use  (s2RaUse),
    .s2_rb_use  (s2RbUse),
    .s2_rc_use  (s2RcUse),
    .s2_reg_dst (s2RegDst),
    .s2_reg_wr  (s2RegWr),
    .s2_latency (s2Latency),
    .s2_pipe    (s2Pipe),
    .issue1     (issue1),
    .issue2     (issue2),
    .stall      (stall),
    .flush      (flush)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Slot setters: a source whose use flag is 0 is ignored by the DUT.
  task automatic setS1(input logic [6:0] ra, input logic raU, input logic [6:0] rb,
                       input logic rbU, input logic [6:0] rc, input logic rcU,
                       input logic [6:0] dst, input logic wr, input logic [3:0] lat,
                       input logic pipe);
    s1RaAddr = ra;  s1RaUse = raU;
    s1RbAddr = rb;  s1RbUse = rbU;
    s1RcAddr = rc;  s1RcUse = rcU;
    s1RegDst = dst; s1RegWr = wr; s1Latency = lat; s1Pipe = pipe;
  endtask

  task automatic setS2(input logic [6:0] ra, input logic raU, input logic [6:0] rb,
                       input logic rbU, input logic [6:0] rc, input logic rcU,
                       input logic [6:0] dst, input logic wr, input logic [3:0] lat,
                       input logic pipe);
    s2RaAddr = ra;  s2RaUse = raU;
    s2RbAddr = rb;  s2RbUse = rbU;
    s2RcAddr = rc;  s2RcUse = rcU;
    s2RegDst = dst; s2RegWr = wr; s2Latency = lat; s2Pipe = pipe;
  endtask

  task automatic applyStimulus(input logic valid, input logic flushIn);
    pairValid = valid;
    flush     = flushIn;
  endtask

  // Compares {issue1, issue2, stall, pair_ready} under a care mask.
  task automatic checkOutput(input string tag, input logic [3:0] expected,
                             input logic [3:0] mask = 4'b1111);
    logic [3:0] observed;
    observed = {issue1, issue2, stall, pairReady} & mask;
    testsRun++;
    assert (observed === (expected & mask))
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed i1/i2/stall/ready=%b expected=%b",
             tag, observed, expected & mask);
    end
  endtask

  // Check on the falling edge, then move to just after the next rising edge.
  task automatic stepCheck(input string tag, input logic [3:0] expected,
                           input logic [3:0] mask = 4'b1111);
    @(negedge clk);
    checkOutput(tag, expected, mask);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted with a clean, valid pair: outputs must still be 0.
    rstN = 1'b0;
    applyStimulus(1'b1, 1'b0);
    setS1(7'd1, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_EVEN);
    setS2(7'd2, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_ODD);
    #3;
    checkOutput("reset_outputs", 4'b0000);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // s1 writes r5 (L=4), s2 independent on the odd pipe: dual issue.
    setS1(7'd1, 1'b1, 7'd2, 1'b1, 7'd0, 1'b0, 7'd5, 1'b1, 4'd4, PIPE_EVEN);
    setS2(7'd10, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd6, 1'b1, 4'd1, PIPE_ODD);
    stepCheck("raw_producer_dual", 4'b1101);
    // Reader of r5 stalls three cycles and issues on the fourth.
    setS1(7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_EVEN);
    setS2(7'd21, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_ODD);
    stepCheck("raw_stall_c1", 4'b0010);
    stepCheck("raw_stall_c2", 4'b0010);
    stepCheck("raw_stall_c3", 4'b0010);
    stepCheck("raw_issue_c4", 4'b1101);

    // s2 reads s1's dst r9 (L=3): split issue, s2 waits for r9.
    setS1(7'd40, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd9, 1'b1, 4'd3, PIPE_EVEN);
    setS2(7'd9, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd11, 1'b1, 4'd2, PIPE_ODD);
    stepCheck("inpair_raw_issue1", 4'b1000);
    stepCheck("inpair_raw_wait1", 4'b0010);
    stepCheck("inpair_raw_wait2", 4'b0010);
    stepCheck("inpair_raw_issue2", 4'b0101);
    // s2 loaded r11 with L=2: its reader waits exactly one cycle.
    setS1(7'd11, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_EVEN);
    setS2(7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_ODD);
    stepCheck("lat2_reader_wait", 4'b0010);
    stepCheck("lat2_reader_issue", 4'b1101);

    // Latency 1 never blocks the next cycle's reader (uses rc port).
    setS1(7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd30, 1'b1, 4'd1, PIPE_EVEN);
    stepCheck("lat1_producer", 4'b1101);
    setS1(7'd0, 1'b0, 7'd0, 1'b0, 7'd30, 1'b1, 7'd0, 1'b0, 4'd0, PIPE_EVEN);
    stepCheck("lat1_reader_now", 4'b1101);

    // Both slots on the even pipe, independent: issue1 then issue2.
    setS1(7'd41, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd42, 1'b1, 4'd1, PIPE_EVEN);
    setS2(7'd43, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd44, 1'b1, 4'd0, PIPE_EVEN);
    stepCheck("struct_issue1", 4'b1000);
    stepCheck("struct_issue2", 4'b0101);

    // WAW on r3: s1 L=6, s2 L=2. s2 waits until r3 drains, then loads 2.
    setS1(7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd3, 1'b1, 4'd6, PIPE_EVEN);
    setS2(7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd3, 1'b1, 4'd2, PIPE_ODD);
    stepCheck("waw_issue1", 4'b1000);
    for (int i = 0; i < 5; i++) begin
      stepCheck($sformatf("waw_wait%0d", i), 4'b0010);
    end
    stepCheck("waw_issue2", 4'b0101);
    setS1(7'd0, 1'b0, 7'd3, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_EVEN);
    setS2(7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_ODD);
    stepCheck("waw_reader_wait", 4'b0010);
    stepCheck("waw_reader_issue", 4'b1101);

    // Flush one cycle after reserving r7 retracts it.
    setS1(7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd7, 1'b1, 4'd6, PIPE_EVEN);
    stepCheck("flush_producer", 4'b1101);
    setS1(7'd7, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_EVEN);
    applyStimulus(1'b1, 1'b1);
    stepCheck("flush_suppress", 4'b0000, 4'b1101);
    applyStimulus(1'b1, 1'b0);
    stepCheck("flush_reader_now", 4'b1101);

    // Reservation two issue cycles old (oldest history slot) is retracted.
    setS1(7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd50, 1'b1, 4'd8, PIPE_EVEN);
    stepCheck("flush2_producer", 4'b1101);
    applyStimulus(1'b0, 1'b0);
    stepCheck("flush2_idle", 4'b0000);
    applyStimulus(1'b0, 1'b1);
    stepCheck("flush2_flush", 4'b0000);
    applyStimulus(1'b1, 1'b0);
    setS1(7'd50, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_EVEN);
    stepCheck("flush2_reader_now", 4'b1101);

    // Reservation older than the flush window survives the flush.
    setS1(7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd51, 1'b1, 4'd8, PIPE_EVEN);
    stepCheck("flush3_producer", 4'b1101);
    applyStimulus(1'b0, 1'b0);
    stepCheck("flush3_idle1", 4'b0000);
    stepCheck("flush3_idle2", 4'b0000);
    applyStimulus(1'b0, 1'b1);
    stepCheck("flush3_flush", 4'b0000);
    applyStimulus(1'b1, 1'b0);
    setS1(7'd51, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_EVEN);
    stepCheck("flush3_reader_stall", 4'b0010);

    // Enter SECOND with r12 reserved, then reset asynchronously.
    setS1(7'd60, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd12, 1'b1, 4'd6, PIPE_EVEN);
    setS2(7'd12, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_ODD);
    stepCheck("rst_issue1", 4'b1000);
    @(negedge clk);
    checkOutput("rst_second_stall", 4'b0010);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst_async_zero", 4'b0000);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_held_zero", 4'b0000);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    // r12 and r51 both cleared by reset; state back to PAIR.
    setS1(7'd12, 1'b1, 7'd51, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_EVEN);
    setS2(7'd12, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 4'd0, PIPE_ODD);
    stepCheck("rst_reader_now", 4'b1101);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
